// File: rtl/stage_post_rotation.sv
// Three-stage point-in-shape test: stage 1 makes absolute vertices, stage 2 computes edge functions,
// stage 3 classifies and counts. POSTROT_EDGE_INCL_EN makes pixels with E = 0 count as inside.
module stage_post_rotation (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        clear_count,
  input  logic        nst3_bubble,
  input  logic [8:0]  nst3_color,
  input  logic [9:0]  nst3_pixel_x,
  input  logic [9:0]  nst3_pixel_y,
  input  logic [8:0]  nst3_ref_point_x,
  input  logic [8:0]  nst3_ref_point_y,
  input  logic        nst3_form,
  input  logic [18:0] nst3_v1_x,
  input  logic [18:0] nst3_v1_y,
  input  logic [18:0] nst3_v2_x,
  input  logic [18:0] nst3_v2_y,
  input  logic [18:0] nst3_v3_x,
  input  logic [18:0] nst3_v3_y,
  input  logic [18:0] nst3_v4_x,
  input  logic [18:0] nst3_v4_y,
  output logic        out_nst3_bubble,
  output logic [9:0]  out_nst3_pixel_x,
  output logic [9:0]  out_nst3_pixel_y,
  output logic        out_nst3_inside,
  output logic [8:0]  out_nst3_pixel_color,
  output logic [19:0] inside_count
);

  // Stall semantics: stall=1 freezes every stage and the counter; no ready/valid back-pressure.

  // Round-half-up of a Q10.8 offset, then add the unsigned centre; bits [19:8] are the arithmetic shift.
  function automatic logic [11:0] to_abs(input logic [18:0] v, input logic [8:0] rp);
    logic [19:0] r;
    r = {v[18], v} + 20'd128;
    to_abs = r[19:8] + {3'b000, rp};
  endfunction

  function automatic logic signed [26:0] sx(input logic [11:0] a);
    sx = {{15{a[11]}}, a};
  endfunction

  // Differences fit in 13 bits and products in 26, so 27-bit arithmetic never wraps.
  function automatic logic signed [26:0] edge_fn(input logic [11:0] xa, input logic [11:0] ya,
                                                 input logic [11:0] xb, input logic [11:0] yb,
                                                 input logic [11:0] px, input logic [11:0] py);
    logic signed [26:0] dx, dy, qx, qy;
    dx = sx(xb) - sx(xa);
    dy = sx(yb) - sx(ya);
    qx = sx(px) - sx(xa);
    qy = sx(py) - sx(ya);
    edge_fn = dx * qy - dy * qx;
  endfunction

  logic [3:0][11:0] ax_c, ay_c;
  logic             s1_bubble, s1_form;
  logic [8:0]       s1_color;
  logic [11:0]      s1_px, s1_py;
  logic [3:0][11:0] s1_ax, s1_ay;

  logic             s2_bubble, s2_form;
  logic [8:0]       s2_color;
  logic [9:0]       s2_px, s2_py;
  logic [3:0][26:0] e_c, s2_e;

  logic [3:0]       pos_c, neg_c, used_c;
  logic             inside_c;
  logic [19:0]      count_q;

  assign ax_c[0] = to_abs(nst3_v1_x, nst3_ref_point_x);
  assign ay_c[0] = to_abs(nst3_v1_y, nst3_ref_point_y);
  assign ax_c[1] = to_abs(nst3_v2_x, nst3_ref_point_x);
  assign ay_c[1] = to_abs(nst3_v2_y, nst3_ref_point_y);
  assign ax_c[2] = to_abs(nst3_v3_x, nst3_ref_point_x);
  assign ay_c[2] = to_abs(nst3_v3_y, nst3_ref_point_y);
  assign ax_c[3] = to_abs(nst3_v4_x, nst3_ref_point_x);
  assign ay_c[3] = to_abs(nst3_v4_y, nst3_ref_point_y);

  // The closing edge of a triangle returns from v3 to v1; edge 3 is then unused.
  always_comb begin
    e_c[0] = edge_fn(s1_ax[0], s1_ay[0], s1_ax[1], s1_ay[1], s1_px, s1_py);
    e_c[1] = edge_fn(s1_ax[1], s1_ay[1], s1_ax[2], s1_ay[2], s1_px, s1_py);
    if (s1_form)
      e_c[2] = edge_fn(s1_ax[2], s1_ay[2], s1_ax[0], s1_ay[0], s1_px, s1_py);
    else
      e_c[2] = edge_fn(s1_ax[2], s1_ay[2], s1_ax[3], s1_ay[3], s1_px, s1_py);
    e_c[3] = edge_fn(s1_ax[3], s1_ay[3], s1_ax[0], s1_ay[0], s1_px, s1_py);
  end

  always_comb begin
    pos_c  = '0;
    neg_c  = '0;
    used_c = {~s2_form, 3'b111};
    for (int k = 0; k < 4; k++) begin
`ifdef POSTROT_EDGE_INCL_EN
      pos_c[k] = ~s2_e[k][26];
      neg_c[k] = s2_e[k][26] | (s2_e[k] == 27'd0);
`else
      pos_c[k] = ~s2_e[k][26] & (s2_e[k] != 27'd0);
      neg_c[k] = s2_e[k][26];
`endif
    end
    inside_c = ~s2_bubble & ((&(pos_c | ~used_c)) | (&(neg_c | ~used_c)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_bubble            <= 1'b1;
      s1_form              <= 1'b0;
      s1_color             <= '0;
      s1_px                <= '0;
      s1_py                <= '0;
      s1_ax                <= '0;
      s1_ay                <= '0;
      s2_bubble            <= 1'b1;
      s2_form              <= 1'b0;
      s2_color             <= '0;
      s2_px                <= '0;
      s2_py                <= '0;
      s2_e                 <= '0;
      out_nst3_bubble      <= 1'b1;
      out_nst3_pixel_x     <= '0;
      out_nst3_pixel_y     <= '0;
      out_nst3_inside      <= 1'b0;
      out_nst3_pixel_color <= '0;
    end else if (!stall) begin
      s1_bubble            <= nst3_bubble;
      s1_form              <= nst3_form;
      s1_color             <= nst3_color;
      s1_px                <= {2'b00, nst3_pixel_x};
      s1_py                <= {2'b00, nst3_pixel_y};
      s1_ax                <= ax_c;
      s1_ay                <= ay_c;
      s2_bubble            <= s1_bubble;
      s2_form              <= s1_form;
      s2_color             <= s1_color;
      s2_px                <= s1_px[9:0];
      s2_py                <= s1_py[9:0];
      s2_e                 <= e_c;
      out_nst3_bubble      <= s2_bubble;
      out_nst3_pixel_x     <= s2_px;
      out_nst3_pixel_y     <= s2_py;
      out_nst3_inside      <= inside_c;
      out_nst3_pixel_color <= inside_c ? s2_color : 9'h000;
    end
  end

  // clear_count beats both stall and a simultaneous increment.
  always_ff @(posedge clk) begin
    if (reset || clear_count)
      count_q <= '0;
    else if (!stall && inside_c && (count_q != 20'hFFFFF))
      count_q <= count_q + 20'd1;
  end

  assign inside_count = count_q;

endmodule

// File: tb/tb_stage_post_rotation.sv
// Directed bench for stage_post_rotation: square/triangle classification, stall, reset flush, counter.
module tb_stage_post_rotation;

  logic        clk = 1'b0;
  logic        reset, stall, clear_count, bub, form;
  logic [8:0]  color, rx, ry;
  logic [9:0]  px, py;
  logic [18:0] v1x, v1y, v2x, v2y, v3x, v3y, v4x, v4y;
  logic        o_bub, o_inside;
  logic [9:0]  o_x, o_y;
  logic [8:0]  o_color;
  logic [19:0] cnt;

  int errors = 0;
  int checks = 0;
  int exp_cnt;
  logic edge_exp;

  stage_post_rotation dut (
    .clk(clk), .reset(reset), .stall(stall), .clear_count(clear_count),
    .nst3_bubble(bub), .nst3_color(color), .nst3_pixel_x(px), .nst3_pixel_y(py),
    .nst3_ref_point_x(rx), .nst3_ref_point_y(ry), .nst3_form(form),
    .nst3_v1_x(v1x), .nst3_v1_y(v1y), .nst3_v2_x(v2x), .nst3_v2_y(v2y),
    .nst3_v3_x(v3x), .nst3_v3_y(v3y), .nst3_v4_x(v4x), .nst3_v4_y(v4y),
    .out_nst3_bubble(o_bub), .out_nst3_pixel_x(o_x), .out_nst3_pixel_y(o_y),
    .out_nst3_inside(o_inside), .out_nst3_pixel_color(o_color), .inside_count(cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [9:0] x, input logic [9:0] y);
    bub = 1'b0; px = x; py = y;
    step();
    bub = 1'b1;
    step();
    step();
  endtask

  task automatic set_square();
    form = 1'b0;
    v1x = -19'sd2560; v1y = -19'sd2560;
    v2x =  19'sd2560; v2y = -19'sd2560;
    v3x =  19'sd2560; v3y =  19'sd2560;
    v4x = -19'sd2560; v4y =  19'sd2560;
  endtask

  initial begin
`ifdef POSTROT_EDGE_INCL_EN
    edge_exp = 1'b1;
`else
    edge_exp = 1'b0;
`endif
    reset = 1'b1; stall = 1'b0; clear_count = 1'b0; bub = 1'b1;
    color = 9'h1A5; rx = 9'd100; ry = 9'd100; px = '0; py = '0;
    set_square();
    step();
    step();
    chk("reset_bubble", {19'd0, o_bub}, 20'd1);
    chk("reset_inside", {19'd0, o_inside}, 20'd0);
    chk("reset_color", {11'd0, o_color}, 20'd0);
    chk("reset_x", {10'd0, o_x}, 20'd0);
    chk("reset_y", {10'd0, o_y}, 20'd0);
    chk("reset_count", cnt, 20'd0);
    reset = 1'b0;

    // Square spans 90..110 in both axes.
    send(10'd105, 10'd95);
    chk("sq_in_bubble", {19'd0, o_bub}, 20'd0);
    chk("sq_in_inside", {19'd0, o_inside}, 20'd1);
    chk("sq_in_color", {11'd0, o_color}, 20'h1A5);
    chk("sq_in_x", {10'd0, o_x}, 20'd105);
    chk("sq_in_y", {10'd0, o_y}, 20'd95);
    chk("sq_in_count", cnt, 20'd1);
    send(10'd120, 10'd100);
    chk("sq_out_inside", {19'd0, o_inside}, 20'd0);
    chk("sq_out_color", {11'd0, o_color}, 20'd0);
    chk("sq_out_count", cnt, 20'd1);
    send(10'd110, 10'd100);
    exp_cnt = 1 + int'(edge_exp);
    chk("sq_edge_inside", {19'd0, o_inside}, {19'd0, edge_exp});
    chk("sq_edge_count", cnt, 20'(exp_cnt));

    // Triangle (100,90),(90,110),(110,110); v4 lands at (120,120) and must be ignored.
    form = 1'b1;
    v1x = 19'sd0;     v1y = -19'sd2560;
    v2x = -19'sd2560; v2y =  19'sd2560;
    v3x =  19'sd2560; v3y =  19'sd2560;
    v4x =  19'sd5000; v4y =  19'sd5000;
    send(10'd100, 10'd105);
    chk("tri_in_inside", {19'd0, o_inside}, 20'd1);
    chk("tri_in_color", {11'd0, o_color}, 20'h1A5);
    send(10'd92, 10'd92);
    chk("tri_out_inside", {19'd0, o_inside}, 20'd0);
    chk("tri_count", cnt, 20'(exp_cnt + 1));

    // Stream with a 2-cycle stall after three pixels have entered.
    reset = 1'b1; step(); reset = 1'b0;
    set_square();
    bub = 1'b0; px = 10'd105; py = 10'd95;  step();
    px = 10'd120; py = 10'd100;             step();
    px = 10'd100; py = 10'd100;             step();
    chk("st_a_x", {10'd0, o_x}, 20'd105);
    chk("st_a_inside", {19'd0, o_inside}, 20'd1);
    chk("st_a_count", cnt, 20'd1);
    stall = 1'b1; px = 10'd95; py = 10'd105; step();
    chk("st_hold1_x", {10'd0, o_x}, 20'd105);
    chk("st_hold1_bubble", {19'd0, o_bub}, 20'd0);
    chk("st_hold1_count", cnt, 20'd1);
    step();
    chk("st_hold2_x", {10'd0, o_x}, 20'd105);
    chk("st_hold2_count", cnt, 20'd1);
    stall = 1'b0; step();
    chk("st_b_x", {10'd0, o_x}, 20'd120);
    chk("st_b_inside", {19'd0, o_inside}, 20'd0);
    bub = 1'b1; step();
    chk("st_c_x", {10'd0, o_x}, 20'd100);
    chk("st_c_inside", {19'd0, o_inside}, 20'd1);
    chk("st_c_count", cnt, 20'd2);
    step();
    chk("st_d_x", {10'd0, o_x}, 20'd95);
    chk("st_d_y", {10'd0, o_y}, 20'd105);
    chk("st_d_inside", {19'd0, o_inside}, 20'd1);
    chk("st_d_count", cnt, 20'd3);

    // Reset with pixels in flight, asserted under stall.
    bub = 1'b0; px = 10'd100; py = 10'd100;
    step(); step(); step();
    chk("flight_count", cnt, 20'd4);
    reset = 1'b1; stall = 1'b1; step();
    chk("flush_rst_bubble", {19'd0, o_bub}, 20'd1);
    chk("flush_rst_count", cnt, 20'd0);
    reset = 1'b0; stall = 1'b0; bub = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("flush%0d_bubble", i), {19'd0, o_bub}, 20'd1);
      chk($sformatf("flush%0d_inside", i), {19'd0, o_inside}, 20'd0);
      chk($sformatf("flush%0d_count", i), cnt, 20'd0);
    end

    // Saturation from a preloaded full counter.
    dut.count_q = 20'hFFFFF;
    send(10'd100, 10'd100);
    chk("sat_inside", {19'd0, o_inside}, 20'd1);
    chk("sat_count", cnt, 20'hFFFFF);

    // Clear alone, clear colliding with an increment, clear under stall.
    clear_count = 1'b1; step(); clear_count = 1'b0;
    chk("clr_count", cnt, 20'd0);
    bub = 1'b0; px = 10'd100; py = 10'd100; step();
    bub = 1'b1; step();
    clear_count = 1'b1; step(); clear_count = 1'b0;
    chk("clr_inc_inside", {19'd0, o_inside}, 20'd1);
    chk("clr_inc_count", cnt, 20'd0);
    send(10'd100, 10'd100);
    chk("pre_stall_clr_count", cnt, 20'd1);
    stall = 1'b1; clear_count = 1'b1; step();
    stall = 1'b0; clear_count = 1'b0;
    chk("stall_clr_count", cnt, 20'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
